// File: rtl/result_accum_pkg.sv
// Shared types and sizing for the result accumulator: FSM state encoding,
// upstream result width and the window-sum width helper.
package result_accum_pkg;

  localparam int RESULT_W = 17;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } accState_e;

  // A window of 2^lenLog2 full-scale results fits exactly in this many bits.
  function automatic int sumWidth(input int lenLog2);
    return RESULT_W + lenLog2;
  endfunction

endpackage

// File: rtl/result_accum_ctrl.sv
// Window controller for result_accum: ACC/HOLD state machine and beat counter.
// Emits one-cycle strobes for accepted beats, the closing beat and the output release.
module result_accum_ctrl
  import result_accum_pkg::*;
#(
  parameter int ACC_LEN_LOG2 = 3
) (
  input  logic      iCLK,
  input  logic      iRST,
  input  logic      iCLR,
  input  logic      iVALID,
  input  logic      iREADY,
  output logic      oAccept,
  output logic      oLast,
  output logic      oRelease,
  output accState_e oState
);

  localparam logic [ACC_LEN_LOG2-1:0] LAST_CNT = '1;
  localparam logic [ACC_LEN_LOG2-1:0] ONE      = 1;

  accState_e               state, stateNext;
  logic [ACC_LEN_LOG2-1:0] count, countNext;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ACC;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  // Handshake: a beat is taken when iVALID is high in ACC (oREADY = ACC);
  // the window result is released when iREADY is high in HOLD (oVALID = HOLD).
  // iCLR overrides both, dropping the beat or the pending result.
  always_comb begin
    stateNext = state;
    countNext = count;
    oAccept   = 1'b0;
    oLast     = 1'b0;
    oRelease  = 1'b0;
    if (iCLR) begin
      stateNext = ACC;
      countNext = '0;
    end else begin
      case (state)
        ACC: begin
          if (iVALID) begin
            oAccept   = 1'b1;
            countNext = count + ONE;
            if (count == LAST_CNT) begin
              oLast     = 1'b1;
              stateNext = HOLD;
            end
          end
        end
        HOLD: begin
          if (iREADY) begin
            oRelease  = 1'b1;
            stateNext = ACC;
            countNext = '0;
          end
        end
        default: stateNext = ACC;
      endcase
    end
  end

  assign oState = state;

endmodule

// File: rtl/result_accum.sv
// Windowed accumulator: sums 2^ACC_LEN_LOG2 upstream results, then presents sum and mean.
// Optional feature macro RESULT_ACCUM_MAX_EN adds oMAX, the window's largest result.
module result_accum
  import result_accum_pkg::*;
#(
  parameter  int ACC_LEN_LOG2 = 3,
  localparam int SUM_W        = sumWidth(ACC_LEN_LOG2)
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iCLR,
  input  logic                iVALID,
  input  logic [RESULT_W-1:0] iRESULT,
  output logic                oREADY,
  output logic                oVALID,
  input  logic                iREADY,
  output logic [SUM_W-1:0]    oSUM,
  output logic [RESULT_W-1:0] oAVG
`ifdef RESULT_ACCUM_MAX_EN
  ,
  output logic [RESULT_W-1:0] oMAX
`endif
);

  accState_e        ctrlState;
  logic             beatAcc;
  logic             beatLast;
  logic             winRelease;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sumNext;

  result_accum_ctrl #(
    .ACC_LEN_LOG2(ACC_LEN_LOG2)
  ) uCtrl (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iCLR    (iCLR),
    .iVALID  (iVALID),
    .iREADY  (iREADY),
    .oAccept (beatAcc),
    .oLast   (beatLast),
    .oRelease(winRelease),
    .oState  (ctrlState)
  );

  assign oREADY  = (ctrlState == ACC);
  assign oVALID  = (ctrlState == HOLD);
  assign sumNext = sum + SUM_W'(iRESULT);

  // The closing beat's sum goes straight to the outputs so they update on that edge.
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      sum  <= '0;
      oSUM <= '0;
      oAVG <= '0;
    end else begin
      if (beatAcc) sum <= sumNext;
      if (beatLast) begin
        oSUM <= sumNext;
        oAVG <= sumNext[SUM_W-1:ACC_LEN_LOG2];
      end
      if (winRelease) sum <= '0;
    end
  end

`ifdef RESULT_ACCUM_MAX_EN
  logic [RESULT_W-1:0] maxTrack;
  logic [RESULT_W-1:0] maxNext;

  assign maxNext = (iRESULT > maxTrack) ? iRESULT : maxTrack;

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      maxTrack <= '0;
      oMAX     <= '0;
    end else begin
      if (beatAcc) maxTrack <= maxNext;
      if (beatLast) oMAX <= maxNext;
      if (winRelease) maxTrack <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_result_accum.sv
// Self-checking bench for result_accum with N = 8; define RESULT_ACCUM_MAX_EN
// on both bench and RTL to exercise oMAX.
module tb_result_accum;

  localparam int LOG2 = 3;
  localparam int N    = 8;

  logic        iCLK = 1'b0;
  logic        iRST, iCLR, iVALID, iREADY;
  logic [16:0] iRESULT;
  logic        oREADY, oVALID;
  logic [19:0] oSUM;
  logic [16:0] oAVG;
`ifdef RESULT_ACCUM_MAX_EN
  logic [16:0] oMAX;
`endif

  int nVec = 0;
  int nErr = 0;

  // Reference model and scoreboard
  logic        mHold;
  logic [19:0] mSum;
  int          mCnt;
  logic [16:0] mMax;
  logic [19:0] exp_q[$];
  logic [16:0] expMax_q[$];

  result_accum #(.ACC_LEN_LOG2(LOG2)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iCLR   (iCLR),
    .iVALID (iVALID),
    .iRESULT(iRESULT),
    .oREADY (oREADY),
    .oVALID (oVALID),
    .iREADY (iREADY),
    .oSUM   (oSUM),
    .oAVG   (oAVG)
`ifdef RESULT_ACCUM_MAX_EN
    ,
    .oMAX   (oMAX)
`endif
  );

  // Clock / reset block
  always #5 iCLK = ~iCLK;

  // Advances one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    if (iRST || iCLR) begin
      mHold = 1'b0; mSum = '0; mCnt = 0; mMax = '0;
      exp_q.delete();
      expMax_q.delete();
    end else if (mHold) begin
      if (iREADY) mHold = 1'b0;
    end else if (iVALID) begin
      mSum += 20'(iRESULT);
      if (iRESULT > mMax) mMax = iRESULT;
      mCnt++;
      if (mCnt == N) begin
        exp_q.push_back(mSum);
        expMax_q.push_back(mMax);
        mHold = 1'b1; mSum = '0; mCnt = 0; mMax = '0;
      end
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic driveBeats(input int n, input logic [16:0] val, input logic rdy);
    iREADY = rdy;
    for (int i = 0; i < n; i++) begin
      iVALID  = 1'b1;
      iRESULT = val;
      tick();
    end
    iVALID = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1; iCLR = 1'b0; iVALID = 1'b0; iREADY = 1'b0; iRESULT = '0;
    tick();
    tick();
    iRST = 1'b0;
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %b want 0", oVALID); end
    nVec++; if (oREADY !== 1'b1) begin nErr++; $display("FAIL reset_ready: got %b want 1", oREADY); end
    nVec++; if (oSUM !== 20'd0) begin nErr++; $display("FAIL reset_sum: got %0d want 0", oSUM); end
    nVec++; if (oAVG !== 17'd0) begin nErr++; $display("FAIL reset_avg: got %0d want 0", oAVG); end
`ifdef RESULT_ACCUM_MAX_EN
    nVec++; if (oMAX !== 17'd0) begin nErr++; $display("FAIL reset_max: got %0d want 0", oMAX); end
`endif
  endtask

  task automatic test_basic();
    logic [19:0] exp;
    driveBeats(N - 1, 17'd100, 1'b1);
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL basic_early_valid: got %b want 0", oVALID); end
    nVec++; if (oSUM !== 20'd0) begin nErr++; $display("FAIL basic_acc_sum_stable: got %0d want 0", oSUM); end
    driveBeats(1, 17'd100, 1'b1);
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL basic_valid: got %b want 1", oVALID); end
    nVec++; if (oREADY !== 1'b0) begin nErr++; $display("FAIL basic_hold_ready: got %b want 0", oREADY); end
    exp = exp_q.pop_front();
    nVec++; if (oSUM !== exp || oSUM !== 20'd800) begin nErr++; $display("FAIL basic_sum: got %0d want %0d", oSUM, exp); end
    nVec++; if (oAVG !== exp[19:3] || oAVG !== 17'd100) begin nErr++; $display("FAIL basic_avg: got %0d want %0d", oAVG, exp[19:3]); end
    tick();
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL basic_valid_one_cycle: got %b want 0", oVALID); end
    nVec++; if (oSUM !== exp) begin nErr++; $display("FAIL basic_sum_after_release: got %0d want %0d", oSUM, exp); end
  endtask

  task automatic test_full_scale();
    logic [19:0] exp;
    driveBeats(N, 17'h1FFFF, 1'b1);
    exp = exp_q.pop_front();
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL full_valid: got %b want 1", oVALID); end
    nVec++; if (oSUM !== exp || oSUM !== 20'hFFFF8) begin nErr++; $display("FAIL full_sum: got %0d want %0d", oSUM, exp); end
    nVec++; if (oAVG !== 17'd131071) begin nErr++; $display("FAIL full_avg: got %0d want 131071", oAVG); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [19:0] exp;
    driveBeats(N, 17'd1234, 1'b0);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      iVALID = 1'b1; iRESULT = 17'd5;
      tick();
      nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL bp_valid[%0d]: got %b want 1", i, oVALID); end
      nVec++; if (oREADY !== 1'b0) begin nErr++; $display("FAIL bp_ready[%0d]: got %b want 0", i, oREADY); end
      nVec++; if (oSUM !== exp || oSUM !== 20'd9872) begin nErr++; $display("FAIL bp_sum[%0d]: got %0d want %0d", i, oSUM, exp); end
    end
    iREADY = 1'b1;
    tick();
    iVALID = 1'b0;
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL bp_release_valid: got %b want 0", oVALID); end
    nVec++; if (oREADY !== 1'b1) begin nErr++; $display("FAIL bp_release_ready: got %b want 1", oREADY); end
    driveBeats(N, 17'd3, 1'b1);
    exp = exp_q.pop_front();
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL bp_next_valid: got %b want 1", oVALID); end
    nVec++; if (oSUM !== exp || oSUM !== 20'd24) begin nErr++; $display("FAIL bp_next_sum: got %0d want %0d", oSUM, exp); end
    tick();
  endtask

  task automatic test_clear();
    logic [19:0] exp;
    driveBeats(3, 17'd50, 1'b1);
    iCLR = 1'b1; iVALID = 1'b1; iRESULT = 17'd50;
    tick();
    iCLR = 1'b0; iVALID = 1'b0;
    nVec++; if (oSUM !== 20'd0) begin nErr++; $display("FAIL clr_sum: got %0d want 0", oSUM); end
    nVec++; if (oREADY !== 1'b1) begin nErr++; $display("FAIL clr_ready: got %b want 1", oREADY); end
    driveBeats(N, 17'd10, 1'b1);
    exp = exp_q.pop_front();
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL clr_next_valid: got %b want 1", oVALID); end
    nVec++; if (oSUM !== exp || oSUM !== 20'd80) begin nErr++; $display("FAIL clr_next_sum: got %0d want %0d", oSUM, exp); end
    nVec++; if (oAVG !== 17'd10) begin nErr++; $display("FAIL clr_next_avg: got %0d want 10", oAVG); end
    tick();
    // Clear while holding a result, racing the handshake
    driveBeats(N, 17'd9, 1'b0);
    iCLR = 1'b1; iREADY = 1'b1;
    tick();
    iCLR = 1'b0;
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL clr_hold_valid: got %b want 0", oVALID); end
    nVec++; if (oSUM !== 20'd0) begin nErr++; $display("FAIL clr_hold_sum: got %0d want 0", oSUM); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    driveBeats(N, 17'd11, 1'b0);
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL rst_pre_valid: got %b want 1", oVALID); end
    iRST = 1'b1; iCLR = 1'b1; iREADY = 1'b1;
    tick();
    iRST = 1'b0; iCLR = 1'b0;
    nVec++; if (oVALID !== 1'b0) begin nErr++; $display("FAIL rst_hold_valid: got %b want 0", oVALID); end
    nVec++; if (oSUM !== 20'd0) begin nErr++; $display("FAIL rst_hold_sum: got %0d want 0", oSUM); end
    nVec++; if (oAVG !== 17'd0) begin nErr++; $display("FAIL rst_hold_avg: got %0d want 0", oAVG); end
    driveBeats(4, 17'd20, 1'b1);
    iRST = 1'b1; iVALID = 1'b1; iRESULT = 17'd20;
    tick();
    iRST = 1'b0; iVALID = 1'b0;
    nVec++; if (oREADY !== 1'b1) begin nErr++; $display("FAIL rst_mid_ready: got %b want 1", oREADY); end
    driveBeats(N, 17'd7, 1'b1);
    exp = exp_q.pop_front();
    nVec++; if (oVALID !== 1'b1) begin nErr++; $display("FAIL rst_fresh_valid: got %b want 1", oVALID); end
    nVec++; if (oSUM !== exp || oSUM !== 20'd56) begin nErr++; $display("FAIL rst_fresh_sum: got %0d want %0d", oSUM, exp); end
    tick();
  endtask

`ifdef RESULT_ACCUM_MAX_EN
  task automatic test_max();
    logic [16:0] vals[8];
    logic [19:0] exp;
    logic [16:0] expMax;
    vals = '{17'd5, 17'd900, 17'd3, 17'd0, 17'd17, 17'd899, 17'd1, 17'd2};
    iREADY = 1'b1;
    foreach (vals[i]) begin
      iVALID = 1'b1; iRESULT = vals[i];
      tick();
    end
    iVALID = 1'b0;
    exp    = exp_q.pop_front();
    expMax = expMax_q.pop_front();
    nVec++; if (oSUM !== exp || oSUM !== 20'd1827) begin nErr++; $display("FAIL max_sum: got %0d want %0d", oSUM, exp); end
    nVec++; if (oAVG !== 17'd228) begin nErr++; $display("FAIL max_avg: got %0d want 228", oAVG); end
    nVec++; if (oMAX !== expMax || oMAX !== 17'd900) begin nErr++; $display("FAIL max_max: got %0d want %0d", oMAX, expMax); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [19:0] cur;
    logic [19:0] lastSum;
    logic        haveCur;
    logic        wasClr;
    iCLR = 1'b1;
    tick();
    iCLR    = 1'b0;
    lastSum = '0;
    haveCur = 1'b0;
    for (int c = 0; c < 400; c++) begin
      iCLR    = ($urandom_range(0, 40) == 0);
      iVALID  = $urandom_range(0, 1);
      iREADY  = ($urandom_range(0, 3) != 0);
      iRESULT = 17'($urandom_range(0, 131071));
      wasClr  = iCLR;
      tick();
      if (wasClr) begin
        lastSum = '0;
        haveCur = 1'b0;
      end else if (haveCur && !mHold) begin
        lastSum = cur;
        haveCur = 1'b0;
      end
      if (mHold && !haveCur && exp_q.size() > 0) begin
        cur     = exp_q.pop_front();
        void'(expMax_q.pop_front());
        haveCur = 1'b1;
      end
      nVec++; if (oVALID !== mHold) begin nErr++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, oVALID, mHold); end
      nVec++; if (oREADY !== !mHold) begin nErr++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, oREADY, !mHold); end
      if (mHold) begin
        nVec++; if (oSUM !== cur) begin nErr++; $display("FAIL rnd_sum[%0d]: got %0d want %0d", c, oSUM, cur); end
        nVec++; if (oAVG !== cur[19:3]) begin nErr++; $display("FAIL rnd_avg[%0d]: got %0d want %0d", c, oAVG, cur[19:3]); end
      end else begin
        nVec++; if (oSUM !== lastSum) begin nErr++; $display("FAIL rnd_sum_stable[%0d]: got %0d want %0d", c, oSUM, lastSum); end
      end
    end
    iCLR = 1'b0; iVALID = 1'b0;
  endtask

  initial begin
    mHold = 1'b0; mSum = '0; mCnt = 0; mMax = '0;
    test_reset();
    test_basic();
    test_full_scale();
    test_backpressure();
    test_clear();
    test_reset_mid();
`ifdef RESULT_ACCUM_MAX_EN
    test_max();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/result_accum.md
RESULT_ACCUM -- requirements
Module: result_accum

Interface
REQ-001 SHALL have parameter ACC_LEN_LOG2, default 3, meaning log2 of window length N (N = 2^ACC_LEN_LOG2, legal range 1..6).
REQ-002 SHALL have port iCLK, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port iRST, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have port iCLR, input, 1, synchronous window clear.
REQ-005 SHALL have port iVALID, input, 1, upstream result valid.
REQ-006 SHALL have port iRESULT, input, 17, the upstream 17-bit product-sum.
REQ-007 SHALL have port oREADY, output, 1, block accepts iRESULT this cycle.
REQ-008 SHALL have port oVALID, output, 1, window result available.
REQ-009 SHALL have port iREADY, input, 1, downstream accepts window result.
REQ-010 SHALL have port oSUM, output, 17+ACC_LEN_LOG2, window sum.
REQ-011 SHALL have port oAVG, output, 17, window mean (oSUM >> ACC_LEN_LOG2, truncated).

Function
REQ-012 SHALL implement FSM states ACC and HOLD only.
REQ-013 SHALL drive oREADY=1 in ACC and oREADY=0 in HOLD; oVALID=1 exactly in HOLD.
REQ-014 SHALL accept a beat when iVALID&&oREADY: sum += zero-extended iRESULT; count += 1.
REQ-015 SHALL, on the Nth accepted beat (count wraps N-1 -> 0), register the final sum into oSUM/oAVG and enter HOLD on the same edge; oVALID is visible the next cycle.
REQ-016 SHALL never overflow: sum width 17+ACC_LEN_LOG2 holds N x (2^17-1) exactly; no saturation logic.
REQ-017 SHALL, in HOLD, keep oSUM/oAVG stable until oVALID&&iREADY, then return to ACC with internal sum and count zeroed on that edge.
REQ-018 SHALL ignore iVALID in HOLD (upstream stalls via oREADY=0); no beat is lost or double-counted.
REQ-019 SHALL, on iCLR=1, zero sum, count, oSUM, oAVG and enter ACC; iCLR takes priority over a simultaneous accepted beat (beat dropped) and over a simultaneous HOLD handshake.
REQ-020 SHALL hold oSUM/oAVG unchanged during ACC (they change only on the REQ-015 edge, iCLR or reset).

Reset
REQ-021 SHALL, on iRST=1 at a rising edge, set state=ACC, sum=0, count=0, oSUM=0, oAVG=0, oVALID=0, oREADY=1 (after release).
REQ-022 SHALL treat iRST as highest priority, overriding iCLR, iVALID and iREADY, including mid-window and in HOLD.

Configuration
REQ-023 SHALL, with macro RESULT_ACCUM_MAX_EN defined, add output port oMAX (17 bits) holding the largest iRESULT accepted in the window, registered alongside oSUM on the REQ-015 edge, internal tracker cleared on reset, iCLR and handshake.
REQ-024 SHALL, without RESULT_ACCUM_MAX_EN, omit oMAX and its tracker entirely; all other behaviour identical.

Structure
REQ-025 SHALL place the state enum (ACC, HOLD), RESULT_W=17 and the sum-width function in shared package result_accum_pkg.
REQ-026 SHALL split the FSM/counter into one sub-module result_accum_ctrl; datapath (sum, outputs, max) stays in result_accum.

Verification (ACC_LEN_LOG2=3, N=8)
REQ-027 SHALL cover: 8 beats of iRESULT=100, iREADY=1 -> oVALID for 1 cycle, oSUM=800, oAVG=100.
REQ-028 SHALL cover: 8 beats of 17'h1FFFF -> oSUM=20'hFFFF8 (1048568), oAVG=131071, no wrap.
REQ-029 SHALL cover: window completes, iREADY=0 for 5 cycles, iVALID held 1 -> oVALID and oSUM stable, oREADY=0, no beat counted; iREADY=1 -> next window starts from 0.
REQ-030 SHALL cover: 3 beats of 50, then iCLR with iVALID=1, then 8 beats of 10 -> oSUM=80, oAVG=10.
REQ-031 SHALL cover: iRST asserted in HOLD and mid-window -> all outputs 0, oVALID=0 next cycle; fresh window of 8 beats of 7 -> oSUM=56.
REQ-032 SHALL cover (RESULT_ACCUM_MAX_EN): beats 5,900,3,0,17,899,1,2 -> oSUM=1827, oAVG=228, oMAX=900.
